// File: rtl/ctrl_leer_dato.sv
// ctrl_leer_dato: read-cycle sequencer for the RTC multiplexed AD bus (address phase, turnaround, strobe, capture).
// Optional build macro LEER_BCD2BIN_EN converts the captured BCD byte to binary before it reaches dato.
module ctrl_leer_dato #(
    parameter int T_PH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enL,
    input  logic [7:0] dir,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic [7:0] dato,
    output logic       ocupado,
    output logic       listo
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SET,
        ST_A_HOLD,
        ST_TURN,
        ST_DATA,
        ST_FIN
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(T_PH - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_dir;

    state_t     w_next;
    logic       w_last;
    logic [7:0] w_addr;
    logic [7:0] w_capt;

    assign w_last = (r_cnt == LP_LAST);
    // On the start edge r_dir is not yet loaded, so the address comes straight from dir.
    assign w_addr = (r_state == ST_IDLE) ? dir : r_dir;

`ifdef LEER_BCD2BIN_EN
    assign w_capt = {1'b0, ad_in[7:4], 3'b000} + {3'b000, ad_in[7:4], 1'b0} + {4'h0, ad_in[3:0]};
`else
    assign w_capt = ad_in;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (enL)    w_next = ST_A_SET;
            ST_A_SET:  if (w_last) w_next = ST_A_HOLD;
            ST_A_HOLD: if (w_last) w_next = ST_TURN;
            ST_TURN:   if (w_last) w_next = ST_DATA;
            ST_DATA:   if (w_last) w_next = ST_FIN;
            ST_FIN:    if (w_last) w_next = ST_IDLE;
            default:               w_next = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so each phase is visible for exactly T_PH cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_dir   <= 8'h00;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            ad_n    <= 1'b1;
            ad_oe   <= 1'b0;
            ad_out  <= 8'h00;
            dato    <= 8'h00;
            ocupado <= 1'b0;
            listo   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == ST_IDLE) ? 8'd0 : r_cnt + 8'd1;
            ocupado <= (w_next != ST_IDLE);
            listo   <= (r_state == ST_FIN) && w_last;

            if (r_state == ST_IDLE && enL) r_dir <= dir;
            if (r_state == ST_DATA && w_last) dato <= w_capt;

            // NOTE: idle levels are assigned first and overridden below; with <= the last assignment wins.
            cs_n   <= 1'b1;
            rd_n   <= 1'b1;
            wr_n   <= 1'b1;
            ad_n   <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= 8'h00;
            case (w_next)
                ST_A_SET: begin
                    cs_n   <= 1'b0;
                    wr_n   <= 1'b0;
                    ad_n   <= 1'b0;
                    ad_oe  <= 1'b1;
                    ad_out <= w_addr;
                end
                ST_A_HOLD: begin
                    cs_n   <= 1'b0;
                    ad_n   <= 1'b0;
                    ad_oe  <= 1'b1;
                    ad_out <= w_addr;
                end
                ST_DATA: begin
                    cs_n <= 1'b0;
                    rd_n <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_leer_dato.sv
// Bench for ctrl_leer_dato: table of read transactions on a T_PH=4 and a T_PH=1 instance, plus reset-abort sequence.
// Expected dato values follow LEER_BCD2BIN_EN when the bench is built with it.
module tb_ctrl_leer_dato;

    logic       clk = 1'b0;
    logic       reset;
    logic       enL;
    logic       sel;
    logic [7:0] dir;
    logic [7:0] ad_in;

    always #5 clk = ~clk;

    logic       en0, en1;
    logic       cs_n0, rd_n0, wr_n0, ad_n0, ad_oe0, ocupado0, listo0;
    logic       cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, ocupado1, listo1;
    logic [7:0] ad_out0, dato0, ad_out1, dato1;

    assign en0 = enL & ~sel;
    assign en1 = enL & sel;

    ctrl_leer_dato #(.T_PH(4)) dut0 (
        .clk(clk), .reset(reset), .enL(en0), .dir(dir),
        .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0), .ad_n(ad_n0),
        .ad_out(ad_out0), .ad_oe(ad_oe0), .ad_in(ad_in),
        .dato(dato0), .ocupado(ocupado0), .listo(listo0)
    );

    ctrl_leer_dato #(.T_PH(1)) dut1 (
        .clk(clk), .reset(reset), .enL(en1), .dir(dir),
        .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .ad_n(ad_n1),
        .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in),
        .dato(dato1), .ocupado(ocupado1), .listo(listo1)
    );

    logic [14:0] mon_bus0, mon_bus1, mon_bus;
    logic [7:0]  mon_dato;
    logic        mon_listo;

    assign mon_bus0  = {cs_n0, rd_n0, wr_n0, ad_n0, ad_oe0, ad_out0, ocupado0, listo0};
    assign mon_bus1  = {cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, ad_out1, ocupado1, listo1};
    assign mon_bus   = sel ? mon_bus1 : mon_bus0;
    assign mon_dato  = sel ? dato1 : dato0;
    assign mon_listo = mon_bus[0];

    typedef struct {
        logic       sel;
        logic [7:0] dir;
        logic [7:0] din;
        logic [7:0] exp_raw;
        logic [7:0] exp_bcd;
        logic       repulse;
        logic       hold;
    } vec_t;

    vec_t       vecs[7];
    vec_t       v_recover;
    logic [7:0] sb_q[$];
    logic [7:0] last_dato[2];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_of(input vec_t v);
`ifdef LEER_BCD2BIN_EN
        return v.exp_bcd;
`else
        return v.exp_raw;
`endif
    endfunction

    // Phase 0..4 = A_SET..FIN, 5 = listo cycle, anything else = plain idle.
    function automatic logic [14:0] model(input int ph, input logic [7:0] d);
        logic       cs = 1'b1, rd = 1'b1, wr = 1'b1, ad = 1'b1, oe = 1'b0, busy = 1'b1, lis = 1'b0;
        logic [7:0] o = 8'h00;
        case (ph)
            0: begin cs = 1'b0; wr = 1'b0; ad = 1'b0; oe = 1'b1; o = d; end
            1: begin cs = 1'b0; ad = 1'b0; oe = 1'b1; o = d; end
            2: ;
            3: begin cs = 1'b0; rd = 1'b0; end
            4: ;
            default: begin busy = 1'b0; lis = (ph == 5); end
        endcase
        return {cs, rd, wr, ad, oe, o, busy, lis};
    endfunction

    task automatic run_read(input vec_t v);
        int         tph  = v.sel ? 1 : 4;
        int         ncyc = 5 * tph + 1;
        logic [7:0] got;
        sel   = v.sel;
        dir   = v.dir;
        ad_in = ~v.din;
        enL   = 1'b1;
        sb_q.push_back(exp_of(v));
        @(posedge clk);
        #1;
        for (int c = 1; c <= ncyc; c++) begin
            int ph = (c - 1) / tph;
            enL   = v.hold || (v.repulse && (c == 5 || c == 14));
            if (!v.hold) dir = ~v.dir;
            ad_in = (ph == 3) ? v.din : ~v.din;
            @(negedge clk);
            check($sformatf("bus sel%0d dir%02h c%0d", v.sel, v.dir, c), mon_bus, model(ph, v.dir));
            if (ph <= 3)
                check($sformatf("dato held c%0d", c), mon_dato, last_dato[sel]);
            else if (ph == 4 && sb_q.size() > 0)
                check($sformatf("dato captured c%0d", c), mon_dato, sb_q[0]);
            if (mon_listo) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("listo spurious c%0d", c), mon_listo, 1'b0);
                end else begin
                    got = sb_q.pop_front();
                    check($sformatf("dato at listo dir%02h", v.dir), mon_dato, got);
                    last_dato[sel] = got;
                end
            end
            if (c != ncyc) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int nlisto;

        vecs[0] = '{1'b0, 8'h21, 8'h59, 8'h59, 8'h3B, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h30, 8'h47, 8'h47, 8'h2F, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h22, 8'h99, 8'h99, 8'h63, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h22, 8'hFF, 8'hFF, 8'hA5, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h05, 8'h12, 8'h12, 8'h0C, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h3C, 8'h80, 8'h80, 8'h50, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        v_recover = '{1'b0, 8'h7E, 8'h36, 8'h36, 8'h24, 1'b0, 1'b0};
        last_dato[0] = 8'h00;
        last_dato[1] = 8'h00;

        reset = 1'b0;
        enL   = 1'b0;
        sel   = 1'b0;
        dir   = 8'h00;
        ad_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset bus t4", mon_bus, model(6, 8'h00));
        check("reset dato t4", mon_dato, 8'h00);
        sel = 1'b1;
        #1;
        check("reset bus t1", mon_bus, model(6, 8'h00));
        check("reset dato t1", mon_dato, 8'h00);
        sel = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_read(vecs[i]);
            if (!vecs[i].hold) begin
                enL = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
        end

        // Abort a read with reset during cycle 14 (second DATA cycle).
        sel   = 1'b0;
        dir   = 8'h44;
        ad_in = 8'h33;
        enL   = 1'b1;
        @(posedge clk);
        #1;
        enL = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 13) check("abort pre rd_n", rd_n0, 1'b0);
            @(posedge clk);
            #1;
        end
        check("abort in DATA rd_n", rd_n0, 1'b0);
        reset = 1'b0;
        #1;
        check("abort bus", mon_bus, model(6, 8'h00));
        check("abort dato", dato0, 8'h00);
        last_dato[0] = 8'h00;
        last_dato[1] = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        nlisto = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (listo0 || ocupado0) nlisto++;
        end
        check("no activity after abort", nlisto, 0);

        @(posedge clk);
        #1;
        run_read(v_recover);
        check("scoreboard drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
